alu_bus_sequencer: RTL

- Host-side front end for the 8-bit serial-bus ALU.
- Accepts one operation per valid/ready request, then drives the ALU through its full transaction: BEGIN pulse, op_code, operand words serialised on inbus.
- Captures the result word(s) from outbus and returns them to the host on a held valid/ready response channel.
- Contains a watchdog that resets a hung ALU and reports an error.

---
 rtl/alu_bus_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_bus_sequencer.sv
// Host-side sequencer for the 8-bit serial-bus ALU: takes one request, serialises it onto
// inbus, captures the result words from outbus and returns them, with a watchdog abort.
module alu_bus_sequencer #(
    parameter int WORD_HOLD = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_x,
    input  logic [7:0] req_y,
    input  logic [7:0] req_z,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       rsp_err,
    output logic       busy,
    output logic       alu_begin,
    output logic [1:0] alu_op_code,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    input  logic       alu_end,
    output logic       alu_reset
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);
    localparam logic [1:0]    HOLD_LAST = 2'(WORD_HOLD - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, RESP, ABORT} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } req_t;

    state_t        state;
    req_t          req_q;
    logic [1:0]    idx;
    logic [1:0]    hold;
    logic [CW-1:0] wdog;
    logic [7:0]    cap0;
    logic [7:0]    cap1;
    logic [1:0]    last_idx;

    function automatic logic [7:0] word_at(input req_t r, input logic [1:0] i);
        case (i)
            2'd0:    return r.x;
            2'd1:    return r.y;
            default: return r.z;
        endcase
    endfunction

    // Division carries a third operand word (the divisor).
    assign last_idx = (req_q.op == 2'b11) ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= '0;
            idx         <= '0;
            hold        <= '0;
            wdog        <= '0;
            cap0        <= '0;
            cap1        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_hi      <= '0;
            rsp_lo      <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= '0;
            alu_inbus   <= '0;
            alu_reset   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state       <= LOAD;
                        req_q       <= '{op: req_op, x: req_x, y: req_y, z: req_z};
                        idx         <= '0;
                        hold        <= '0;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        alu_begin   <= 1'b1;
                        alu_op_code <= req_op;
                        alu_inbus   <= req_x;
                    end
                end
                LOAD: begin
                    alu_begin <= 1'b0;
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        if (idx == last_idx) begin
                            state     <= WAIT;
                            alu_inbus <= '0;
                            wdog      <= '0;
                            cap0      <= '0;
                            cap1      <= '0;
                        end else begin
                            idx       <= idx + 2'd1;
                            alu_inbus <= word_at(req_q, idx + 2'd1);
                        end
                    end else begin
                        hold <= hold + 2'd1;
                    end
                end
                WAIT: begin
                    cap1 <= cap0;
                    cap0 <= alu_outbus;
                    if (wdog != WD_LAST)
                        wdog <= wdog + 1'b1;
                    // END wins over a coincident timeout; cap0 already holds the last word.
                    if (alu_end) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_lo      <= cap0;
                        rsp_hi      <= req_q.op[1] ? cap1 : 8'h00;
                        rsp_err     <= 1'b0;
                        alu_op_code <= '0;
                    end else if (wdog == WD_LAST) begin
                        state       <= ABORT;
                        alu_reset   <= 1'b1;
                        rsp_hi      <= '0;
                        rsp_lo      <= '0;
                        rsp_err     <= 1'b1;
                        alu_op_code <= '0;
                    end
                end
                ABORT: begin
                    alu_reset <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_hi    <= '0;
                        rsp_lo    <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
